// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex UART, parity-protected transmitter and oversampling receiver on a shared baud tick
module uart_txrx #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED = 1,
  parameter int PARITY_TYPE = 0,
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [INPUT_DATA_WIDTH-1:0] i_data,
  output logic o_busy,
  output logic serial_out,
  input  logic serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic data_is_valid,
  output logic rx_error
);
  localparam int W = INPUT_DATA_WIDTH;
  localparam int N = W + PARITY_ENABLED + 2;
  localparam int SW = $clog2(N + 1);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [SW-1:0] IDLE = '0;
  localparam logic [SW-1:0] START_BIT = SW'(1);
  localparam logic [SW-1:0] DATA_BIT_0 = SW'(2);
  localparam logic [SW-1:0] PARITY_BIT = SW'(W + 2);
  localparam logic [SW-1:0] STOP_BIT = SW'(N);

  logic [CW-1:0] baud_cnt;
  logic baud_clk;
  logic [N-1:0] tx_sr;
  logic [N-1:0] tx_frame;
  logic tx_par;
  logic [2:0] sync;
  logic rx_s;
  logic [SW-1:0] rx_state;
  logic [CW-1:0] rx_cnt;
  logic [W-1:0] rx_sh;
  logic rx_par;
  logic sample;
  logic rx_ok;

  assign baud_clk = baud_cnt == CW'(CLOCKS_PER_BIT - 1);
  assign tx_par = PARITY_TYPE != 0 ? ~^i_data : ^i_data;
  assign rx_s = sync[2];
  assign sample = rx_cnt == (rx_state == START_BIT ? CW'(CLOCKS_PER_BIT / 2 - 1) : CW'(CLOCKS_PER_BIT - 1));
  assign rx_ok = rx_s && (PARITY_ENABLED == 0 || rx_par == (PARITY_TYPE != 0 ? ~^rx_sh : ^rx_sh));

  if (PARITY_ENABLED != 0) begin : g_par
    assign tx_frame = {1'b1, tx_par, i_data, 1'b0};
  end else begin : g_nopar
    assign tx_frame = {1'b1, i_data, 1'b0};
  end

  // free-running baud divider shared by transmitter and receiver
  always_ff @(posedge clk)
    if (reset) baud_cnt <= '0;
    else baud_cnt <= baud_clk ? '0 : baud_cnt + 1'b1;

  // transmitter: load the frame when idle, shift one bit per baud tick, release after the stop bit period
  always_ff @(posedge clk)
    if (reset) begin
      tx_sr <= '1;
      serial_out <= 1'b1;
      o_busy <= 1'b0;
    end else if (!o_busy) begin
      if (enable) begin
        tx_sr <= tx_frame;
        o_busy <= 1'b1;
      end
    end else if (baud_clk) begin
      if (tx_sr == '0) o_busy <= 1'b0;
      else begin
        serial_out <= tx_sr[0];
        tx_sr <= tx_sr >> 1;
      end
    end

  // three-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk)
    if (reset) sync <= '1;
    else sync <= {sync[1:0], serial_in};

  // receiver: mid-bit sampling state machine with one-cycle result pulses
  always_ff @(posedge clk)
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_sh <= '0;
      rx_par <= 1'b0;
      received_data <= '0;
      data_is_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      data_is_valid <= 1'b0;
      rx_error <= 1'b0;
      if (rx_state == IDLE) begin
        rx_cnt <= '0;
        if (!rx_s) rx_state <= START_BIT;
      end else if (!sample) rx_cnt <= rx_cnt + 1'b1;
      else begin
        rx_cnt <= '0;
        if (rx_state == START_BIT) rx_state <= rx_s ? IDLE : DATA_BIT_0;
        else if (rx_state == STOP_BIT) begin
          rx_state <= IDLE;
          if (rx_ok) begin
            received_data <= rx_sh;
            data_is_valid <= 1'b1;
          end else rx_error <= 1'b1;
        end else begin
          rx_state <= rx_state + 1'b1;
          if (rx_state == PARITY_BIT && PARITY_ENABLED != 0) rx_par <= rx_s;
          else rx_sh <= {rx_s, rx_sh[W-1:1]};
        end
      end
    end
endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: scoreboard-driven checks of loopback, framing errors, glitches and reset for uart_txrx
module tb_uart_txrx;
  localparam int CPB = 8;
  localparam int N = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [7:0] i_data = '0;
  logic o_busy, serial_out, serial_in, data_is_valid, rx_error;
  logic [7:0] received_data;
  logic loop = 1'b1;
  logic ext_line = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] last_word = 8'h00;
  int checks = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;
  assign serial_in = loop ? serial_out : ext_line;

  uart_txrx #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_TYPE(0), .CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .i_data(i_data), .o_busy(o_busy),
    .serial_out(serial_out), .serial_in(serial_in), .received_data(received_data),
    .data_is_valid(data_is_valid), .rx_error(rx_error)
  );

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  always @(negedge clk)
    if (!reset) begin
      if (data_is_valid || rx_error) begin
        checks++;
        if (data_is_valid && rx_error) begin
          fails++;
          $display("FAIL pulse_exclusive: valid=%b error=%b, required not both high", data_is_valid, rx_error);
        end
      end
      if (rx_error) err_cnt++;
      if (data_is_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: got word %h, required no word", received_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (received_data !== e) begin
            fails++;
            $display("FAIL scoreboard: got word %h, required %h", received_data, e);
          end
        end
      end
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    while (o_busy && t < 400) begin
      tick(1);
      t++;
    end
    if (o_busy) begin
      checks++;
      fails++;
      $display("FAIL send_wait: busy=%b after %0d cycles, required 0", o_busy, t);
    end
    enable = 1'b1;
    i_data = d;
    exp_q.push_back(d);
    last_word = d;
    tick(1);
    enable = 1'b0;
    i_data = ~d;
    checks++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_rise: busy=%b, required 1", o_busy);
    end
  endtask

  task automatic capture(output logic [10:0] bits);
    int t = 0;
    bits = '0;
    while (serial_out !== 1'b0 && t < 400) begin
      tick(1);
      t++;
    end
    if (serial_out !== 1'b0) begin
      checks++;
      fails++;
      $display("FAIL start_bit_wait: serial_out=%b, required 0 within 400 cycles", serial_out);
    end
    tick(CPB / 2 - 1);
    for (int i = 0; i < N; i++) begin
      bits[i] = serial_out;
      if (i < N - 1) tick(CPB);
    end
  endtask

  task automatic wait_valid(input int target);
    int t = 0;
    while (valid_cnt < target && t < 400) begin
      tick(1);
      t++;
    end
    checks++;
    if (valid_cnt < target) begin
      fails++;
      $display("FAIL valid_wait: valid count %0d, required %0d", valid_cnt, target);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
    ext_line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      ext_line = d[i];
      tick(CPB);
    end
    ext_line = par;
    tick(CPB);
    ext_line = stop;
    tick(CPB);
    ext_line = 1'b1;
    tick(CPB * 2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    checks += 5;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    if (serial_out !== 1'b1) begin fails++; $display("FAIL reset_serial_out: got %b, required 1", serial_out); end
    if (received_data !== 8'h00) begin fails++; $display("FAIL reset_received_data: got %h, required 00", received_data); end
    if (data_is_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", data_is_valid); end
    if (rx_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b, required 0", rx_error); end
  endtask

  task automatic test_loopback_a5;
    logic [10:0] bits;
    int v = valid_cnt;
    int e = err_cnt;
    loop = 1'b1;
    send(8'hA5);
    capture(bits);
    wait_valid(v + 1);
    checks += 3;
    if (bits !== frame_of(8'hA5)) begin fails++; $display("FAIL a5_line_bits: got %b, required %b", bits, frame_of(8'hA5)); end
    if (received_data !== 8'hA5) begin fails++; $display("FAIL a5_received: got %h, required a5", received_data); end
    if (err_cnt !== e) begin fails++; $display("FAIL a5_error: got %0d errors, required %0d", err_cnt, e); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] b0, b1;
    int v = valid_cnt;
    int e = err_cnt;
    send(8'h00);
    capture(b0);
    send(8'hFF);
    capture(b1);
    wait_valid(v + 2);
    checks += 5;
    if (b0 !== frame_of(8'h00)) begin fails++; $display("FAIL b2b_frame0: got %b, required %b", b0, frame_of(8'h00)); end
    if (b1 !== frame_of(8'hFF)) begin fails++; $display("FAIL b2b_frame1: got %b, required %b", b1, frame_of(8'hFF)); end
    if (b0[9] !== 1'b0 || b1[9] !== 1'b0) begin fails++; $display("FAIL b2b_parity: got %b %b, required 0 0", b0[9], b1[9]); end
    if (received_data !== 8'hFF) begin fails++; $display("FAIL b2b_received: got %h, required ff", received_data); end
    if (err_cnt !== e) begin fails++; $display("FAIL b2b_error: got %0d errors, required %0d", err_cnt, e); end
  endtask

  task automatic test_enable_held;
    int v, e;
    int cnt = 0;
    int t = 0;
    while (o_busy && t < 400) begin
      tick(1);
      t++;
    end
    v = valid_cnt;
    e = err_cnt;
    enable = 1'b1;
    i_data = 8'h96;
    exp_q.push_back(8'h96);
    last_word = 8'h96;
    tick(1);
    while (o_busy && cnt < 200) begin
      cnt++;
      tick(1);
    end
    enable = 1'b0;
    checks += 2;
    if (cnt < 80 || cnt > 96) begin fails++; $display("FAIL held_busy_len: got %0d cycles, required 80..96", cnt); end
    tick(2);
    if (o_busy !== 1'b0) begin fails++; $display("FAIL held_second_frame: busy=%b, required 0", o_busy); end
    tick(CPB * N * 2);
    checks += 2;
    if (valid_cnt !== v + 1) begin fails++; $display("FAIL held_frame_count: got %0d words, required %0d", valid_cnt - v, 1); end
    if (err_cnt !== e) begin fails++; $display("FAIL held_error: got %0d errors, required %0d", err_cnt, e); end
  endtask

  task automatic test_bad_frames;
    int v = valid_cnt;
    int e = err_cnt;
    loop = 1'b0;
    ext_line = 1'b1;
    tick(CPB);
    drive_frame(8'h5A, ~^8'h5A, 1'b1);
    checks += 3;
    if (err_cnt !== e + 1) begin fails++; $display("FAIL bad_parity_error: got %0d errors, required %0d", err_cnt - e, 1); end
    if (valid_cnt !== v) begin fails++; $display("FAIL bad_parity_valid: got %0d words, required 0", valid_cnt - v); end
    if (received_data !== last_word) begin fails++; $display("FAIL bad_parity_hold: got %h, required %h", received_data, last_word); end
    drive_frame(8'h12, ^8'h12, 1'b0);
    checks += 3;
    if (err_cnt !== e + 2) begin fails++; $display("FAIL bad_stop_error: got %0d errors, required %0d", err_cnt - e, 2); end
    if (valid_cnt !== v) begin fails++; $display("FAIL bad_stop_valid: got %0d words, required 0", valid_cnt - v); end
    if (received_data !== last_word) begin fails++; $display("FAIL bad_stop_hold: got %h, required %h", received_data, last_word); end
    exp_q.push_back(8'hC3);
    last_word = 8'hC3;
    drive_frame(8'hC3, ^8'hC3, 1'b1);
    checks += 2;
    if (valid_cnt !== v + 1) begin fails++; $display("FAIL ext_good_valid: got %0d words, required 1", valid_cnt - v); end
    if (err_cnt !== e + 2) begin fails++; $display("FAIL ext_good_error: got %0d errors, required %0d", err_cnt - e, 2); end
  endtask

  task automatic test_glitch;
    int v = valid_cnt;
    int e = err_cnt;
    ext_line = 1'b0;
    tick(2);
    ext_line = 1'b1;
    tick(CPB * 3);
    checks += 3;
    if (valid_cnt !== v || err_cnt !== e) begin fails++; $display("FAIL glitch_pulses: got %0d words %0d errors, required 0 0", valid_cnt - v, err_cnt - e); end
    if (dut.rx_state !== '0) begin fails++; $display("FAIL glitch_idle: rx state %0d, required 0", dut.rx_state); end
    if (received_data !== last_word) begin fails++; $display("FAIL glitch_hold: got %h, required %h", received_data, last_word); end
  endtask

  task automatic test_reset_midframe;
    int v, e;
    loop = 1'b1;
    send(8'h77);
    tick(CPB * 4);
    reset = 1'b1;
    tick(1);
    checks += 3;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b, required 0", o_busy); end
    if (serial_out !== 1'b1) begin fails++; $display("FAIL midreset_serial_out: got %b, required 1", serial_out); end
    if (dut.rx_state !== '0) begin fails++; $display("FAIL midreset_rx_idle: rx state %0d, required 0", dut.rx_state); end
    exp_q.delete();
    reset = 1'b0;
    v = valid_cnt;
    e = err_cnt;
    tick(CPB * N * 2);
    checks++;
    if (valid_cnt !== v || err_cnt !== e) begin fails++; $display("FAIL midreset_pulses: got %0d words %0d errors, required 0 0", valid_cnt - v, err_cnt - e); end
    send(8'h3C);
    wait_valid(v + 1);
    checks += 2;
    if (received_data !== 8'h3C) begin fails++; $display("FAIL post_reset_word: got %h, required 3c", received_data); end
    if (err_cnt !== e) begin fails++; $display("FAIL post_reset_error: got %0d errors, required %0d", err_cnt - e, 0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_loopback_a5;
    test_back_to_back;
    test_enable_held;
    test_bad_frames;
    test_glitch;
    test_reset_midframe;
    tick(CPB * 4);
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d words outstanding, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
